// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: on an I-cache miss at the fetch PC, stalls fetch, issues one
// AXI4 INCR burst for the line containing the PC, assembles the beats into a cache
// line and pulses the cache write strobe. A bad burst parks the block in FAULT.
//
// Ports:
//   i_clk, i_arst       clock, asynchronous active-high reset
//   i_read_addr         fetch PC
//   i_icache_hit        I-cache hit for i_read_addr (sampled only in IDLE)
//   o_stall_fetch       combinational fetch/PC freeze
//   o_instr_we          one-cycle line write strobe
//   o_instr_block       assembled line (held outside the write cycle)
//   o_fetch_fault       sticky bus-error flag
//   o_axi_ar*           AXI read address channel (len/size/burst are constants)
//   i_axi_r*, o_axi_rready  AXI read data channel
module icache_refill_ctrl #(
  parameter int unsigned ADDR_WIDTH     = 64,
  parameter int unsigned BLOCK_WIDTH    = 512,
  parameter int unsigned AXI_DATA_WIDTH = 64
) (
  input  logic                      i_clk,
  input  logic                      i_arst,
  input  logic [ADDR_WIDTH-1:0]     i_read_addr,
  input  logic                      i_icache_hit,
  output logic                      o_stall_fetch,
  output logic                      o_instr_we,
  output logic [BLOCK_WIDTH-1:0]    o_instr_block,
  output logic                      o_fetch_fault,
  output logic [ADDR_WIDTH-1:0]     o_axi_araddr,
  output logic [7:0]                o_axi_arlen,
  output logic [2:0]                o_axi_arsize,
  output logic [1:0]                o_axi_arburst,
  output logic                      o_axi_arvalid,
  input  logic                      i_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0] i_axi_rdata,
  input  logic [1:0]                i_axi_rresp,
  input  logic                      i_axi_rlast,
  input  logic                      i_axi_rvalid,
  output logic                      o_axi_rready
);

  localparam int unsigned BEATS = BLOCK_WIDTH / AXI_DATA_WIDTH;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned OFF_W = $clog2(BLOCK_WIDTH / 8);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  typedef logic [BEATS-1:0][AXI_DATA_WIDTH-1:0] line_t;

  logic [2:0]            state_q, state_n;
  logic [CNT_W-1:0]      cnt_q, cnt_n;
  logic                  err_q, err_n;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_n;
  logic                  arvalid_q, arvalid_n;
  logic                  rready_q, rready_n;
  logic                  we_q, we_n;
  logic                  fault_q, fault_n;
  line_t                 line_q, line_n;
  line_t                 block_q, block_n;
  logic                  beat;

  // Line offset bits of the PC are dropped by alignment.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_read_addr[OFF_W-1:0];

  // Burst shape is fixed by the line geometry; valid during reset as well.
  assign o_axi_arlen   = 8'(BEATS - 1);
  assign o_axi_arsize  = 3'($clog2(AXI_DATA_WIDTH / 8));
  assign o_axi_arburst = 2'b01;

  assign o_axi_araddr  = araddr_q;
  assign o_axi_arvalid = arvalid_q;
  assign o_axi_rready  = rready_q;
  assign o_instr_we    = we_q;
  assign o_fetch_fault = fault_q;
  assign o_instr_block = block_q;

  // Freeze the PC in the same cycle the miss is seen.
  assign o_stall_fetch = (state_q != S_IDLE) | ~i_icache_hit;

  assign beat = i_axi_rvalid & rready_q;

  // State register and registered outputs.
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      we_q      <= 1'b0;
      fault_q   <= 1'b0;
      line_q    <= '0;
      block_q   <= '0;
    end else begin
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      err_q     <= err_n;
      araddr_q  <= araddr_n;
      arvalid_q <= arvalid_n;
      rready_q  <= rready_n;
      we_q      <= we_n;
      fault_q   <= fault_n;
      line_q    <= line_n;
      block_q   <= block_n;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    err_n    = err_q;
    araddr_n = araddr_q;
    line_n   = line_q;
    block_n  = block_q;

    case (state_q)
      S_IDLE: begin
        if (!i_icache_hit) begin
          araddr_n = {i_read_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          cnt_n    = '0;
          err_n    = 1'b0;
          state_n  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (arvalid_q && i_axi_arready) state_n = S_DATA;
      end
      S_DATA: begin
        if (beat) begin
          line_n[cnt_q] = i_axi_rdata;
          cnt_n         = cnt_q + CNT_W'(1);
          err_n         = err_q | (i_axi_rresp != 2'b00);
          // Errors are only acted on once the burst reaches rlast or its final beat.
          if (i_axi_rlast || (cnt_q == CNT_LAST)) begin
            if (i_axi_rlast && (cnt_q == CNT_LAST) && !err_n) state_n = S_WRITE;
            else                                               state_n = S_FAULT;
          end
        end
      end
      S_WRITE: state_n = S_IDLE;
      S_FAULT: state_n = S_FAULT;
      default: state_n = S_IDLE;
    endcase

    // rready rises the cycle after DATA is entered and drops with the final beat.
    arvalid_n = (state_n == S_ADDR);
    rready_n  = (state_q == S_DATA) && (state_n == S_DATA);
    we_n      = (state_n == S_WRITE);
    fault_n   = (state_n == S_FAULT);
    if (state_n == S_WRITE) block_n = line_n;
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: directed scenarios plus randomized refills, with
// an AXI read slave and a line/timing/outcome reference model.
module tb_icache_refill_ctrl;

  logic         clk;
  logic         arst;
  logic [63:0]  read_addr;
  logic         hit;
  logic         stall;
  logic         we;
  logic [511:0] block;
  logic         fault;
  logic [63:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [63:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  icache_refill_ctrl dut (
    .i_clk(clk), .i_arst(arst), .i_read_addr(read_addr), .i_icache_hit(hit),
    .o_stall_fetch(stall), .o_instr_we(we), .o_instr_block(block), .o_fetch_fault(fault),
    .o_axi_araddr(araddr), .o_axi_arlen(arlen), .o_axi_arsize(arsize), .o_axi_arburst(arburst),
    .o_axi_arvalid(arvalid), .i_axi_arready(arready), .i_axi_rdata(rdata), .i_axi_rresp(rresp),
    .i_axi_rlast(rlast), .i_axi_rvalid(rvalid), .o_axi_rready(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Trial description (slave behaviour)
  logic [63:0] tr_pc;
  int          tr_ar_delay;
  int          tr_gap [8];
  logic [63:0] tr_data [8];
  logic [1:0]  tr_resp [8];
  int          tr_last_at;
  int          tr_abort_beat;

  // Trial observations
  int           ob_t_arvalid, ob_t_we, ob_n_we, ob_n_stall, ob_addr_bad;
  logic [63:0]  ob_hs_addr;
  logic [511:0] ob_blk;
  bit           ob_fault, ob_aborted, ob_timeout;

  task automatic set_trial(input logic [63:0] pc, input int d, input int last_at);
    tr_pc = pc; tr_ar_delay = d; tr_last_at = last_at; tr_abort_beat = -1;
    for (int i = 0; i < 8; i++) begin
      tr_gap[i] = 0; tr_data[i] = 64'(i); tr_resp[i] = 2'b00;
    end
  endtask

  function automatic logic [511:0] model_block();
    logic [511:0] b;
    for (int i = 0; i < 8; i++) b[i*64 +: 64] = tr_data[i];
    return b;
  endfunction

  // Extra cycles over the minimum: AR wait plus every idle cycle between beats.
  function automatic int model_extra();
    int e;
    e = tr_ar_delay;
    for (int i = 1; i < 8; i++) e += tr_gap[i];
    return e;
  endfunction

  function automatic bit model_fault();
    int term;
    bit f;
    term = (tr_last_at < 7) ? tr_last_at : 7;
    f = (tr_last_at != 7);
    for (int i = 0; i <= term; i++) if (tr_resp[i] != 2'b00) f = 1'b1;
    return f;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    arst = 1'b1; hit = 1'b1; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    rresp = 2'b00; rdata = '0; read_addr = '0;
    repeat (2) @(negedge clk);
    arst = 1'b0;
  endtask

  // Drives one miss (cycle 0) and acts as the AXI slave; records what the DUT did.
  task automatic run_miss();
    int ar_seen, k, gap_left;
    bit dphase, rv, ar_fire, r_fire, dropped;
    logic [63:0] exp_addr;
    exp_addr = {tr_pc[63:6], 6'b0};
    ob_t_arvalid = -1; ob_t_we = -1; ob_n_we = 0; ob_n_stall = 0; ob_addr_bad = 0;
    ob_hs_addr = '0; ob_blk = '0; ob_fault = 0; ob_aborted = 0; ob_timeout = 0;
    ar_seen = 0; k = 0; gap_left = 0; dphase = 0; dropped = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      hit       = (cyc == 0) ? 1'b0 : ((ob_t_we >= 0) ? 1'b1 : 1'($urandom_range(0, 1)));
      read_addr = (cyc == 0) ? tr_pc : {$urandom, $urandom};
      arready   = (ar_seen >= tr_ar_delay);
      rv        = dphase && (gap_left == 0) && (k < 8) && (k <= tr_last_at);
      rvalid    = rv;
      rdata     = rv ? tr_data[k] : {$urandom, $urandom};
      rresp     = rv ? tr_resp[k] : 2'b00;
      rlast     = rv && (k == tr_last_at);
      if (rv && (k == tr_abort_beat) && rready) begin
        arst = 1'b1; ob_aborted = 1; return;
      end
      #1;
      if (!dropped) begin
        if (stall) ob_n_stall++; else dropped = 1;
      end
      if (arvalid) begin
        if (ob_t_arvalid < 0) ob_t_arvalid = cyc;
        if (araddr !== exp_addr) ob_addr_bad++;
      end
      if (we) begin
        ob_n_we++;
        if (ob_t_we < 0) begin ob_t_we = cyc; ob_blk = block; end
      end
      ar_fire = arvalid && arready;
      r_fire  = rvalid && rready;
      if (arvalid && !ar_fire) ar_seen++;
      if (ar_fire) begin dphase = 1; ob_hs_addr = araddr; end
      if (r_fire) begin
        k++;
        gap_left = (k < 8) ? tr_gap[k] : 0;
      end else if (dphase && gap_left > 0) begin
        gap_left--;
      end
      if (fault) begin ob_fault = 1; break; end
      if ((ob_t_we >= 0) && (cyc >= ob_t_we + 1)) break;
    end
    if (!ob_fault && ob_t_we < 0) ob_timeout = 1;
    rvalid = 1'b0; rlast = 1'b0; hit = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    arst = 1'b1; hit = 1'b1;
    #1;
    n_checks++; if (arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid got=%b exp=0", arvalid); end
    n_checks++; if (rready !== 1'b0) begin n_fail++; $display("FAIL reset_rready got=%b exp=0", rready); end
    n_checks++; if (we !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL reset_we_fault got=%b%b exp=00", we, fault); end
    n_checks++; if (araddr !== 64'h0 || block !== 512'h0) begin n_fail++; $display("FAIL reset_addr_block addr=%h exp=0", araddr); end
    n_checks++; if (arlen !== 8'd7 || arsize !== 3'd3 || arburst !== 2'b01) begin
      n_fail++; $display("FAIL reset_consts got=%0d/%0d/%0d exp=7/3/1", arlen, arsize, arburst); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", stall); end
    @(negedge clk);
    arst = 1'b0;
  endtask

  task automatic test_hit_only();
    int n_av, n_st, n_we;
    n_av = 0; n_st = 0; n_we = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      hit = 1'b1; read_addr = {$urandom, $urandom}; arready = 1'($urandom_range(0, 1));
      #1;
      if (arvalid) n_av++;
      if (stall) n_st++;
      if (we) n_we++;
    end
    n_checks++; if (n_av != 0 || n_st != 0 || n_we != 0) begin
      n_fail++; $display("FAIL hit_only arvalid/stall/we cycles got=%0d/%0d/%0d exp=0/0/0", n_av, n_st, n_we); end
  endtask

  task automatic test_basic_miss();
    set_trial(64'h8000_0044, 0, 7);
    run_miss();
    n_checks++; if (ob_hs_addr !== 64'h8000_0040) begin n_fail++; $display("FAIL basic_araddr got=%h exp=%h", ob_hs_addr, 64'h8000_0040); end
    n_checks++; if (ob_t_arvalid != 1) begin n_fail++; $display("FAIL basic_arvalid_cycle got=%0d exp=1", ob_t_arvalid); end
    n_checks++; if (ob_t_we != 11 || ob_n_we != 1) begin n_fail++; $display("FAIL basic_we cycle=%0d count=%0d exp=11/1", ob_t_we, ob_n_we); end
    n_checks++; if (ob_blk !== model_block()) begin n_fail++; $display("FAIL basic_block got=%h exp=%h", ob_blk, model_block()); end
    n_checks++; if (ob_n_stall != 12) begin n_fail++; $display("FAIL basic_stall_cycles got=%0d exp=12", ob_n_stall); end
    n_checks++; if (arlen !== 8'd7 || arburst !== 2'b01) begin n_fail++; $display("FAIL basic_arlen_burst got=%0d/%0d exp=7/1", arlen, arburst); end
  endtask

  task automatic test_ar_wait_gaps();
    set_trial(64'h0000_1234_5678_9ABC, 5, 7);
    for (int i = 0; i < 8; i++) tr_data[i] = {$urandom, $urandom};
    for (int i = 1; i < 8; i++) tr_gap[i] = 1;
    run_miss();
    n_checks++; if (ob_addr_bad != 0 || ob_hs_addr !== 64'h0000_1234_5678_9A80) begin
      n_fail++; $display("FAIL wait_araddr bad_cycles=%0d hs=%h exp=0/%h", ob_addr_bad, ob_hs_addr, 64'h0000_1234_5678_9A80); end
    n_checks++; if (ob_t_we != 11 + 12) begin n_fail++; $display("FAIL wait_we_cycle got=%0d exp=23", ob_t_we); end
    n_checks++; if (ob_blk !== model_block()) begin n_fail++; $display("FAIL wait_block got=%h exp=%h", ob_blk, model_block()); end
    n_checks++; if (ob_n_stall != 24) begin n_fail++; $display("FAIL wait_stall_cycles got=%0d exp=24", ob_n_stall); end
  endtask

  task automatic check_fault_hold(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      hit = 1'($urandom_range(0, 1)); read_addr = {$urandom, $urandom};
      #1;
      if (fault !== 1'b1 || stall !== 1'b1 || we !== 1'b0 || arvalid !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL %s_hold bad_cycles=%0d exp=0", name, bad); end
  endtask

  task automatic test_resp_error();
    set_trial(64'h2000, 0, 7);
    tr_resp[3] = 2'b10;
    run_miss();
    n_checks++; if (!ob_fault || ob_n_we != 0) begin n_fail++; $display("FAIL resp_err fault=%0d we=%0d exp=1/0", ob_fault, ob_n_we); end
    check_fault_hold("resp_err");
    apply_reset();
  endtask

  task automatic test_early_last();
    set_trial(64'h3040, 1, 5);
    run_miss();
    n_checks++; if (!ob_fault || ob_n_we != 0) begin n_fail++; $display("FAIL early_last fault=%0d we=%0d exp=1/0", ob_fault, ob_n_we); end
    check_fault_hold("early_last");
    apply_reset();
  endtask

  task automatic test_reset_mid_burst();
    set_trial(64'h4000, 0, 7);
    tr_abort_beat = 4;
    run_miss();
    #1;
    n_checks++; if (!ob_aborted) begin n_fail++; $display("FAIL abort_reached got=0 exp=1"); end
    n_checks++; if (arvalid !== 1'b0 || rready !== 1'b0 || we !== 1'b0 || fault !== 1'b0 || araddr !== 64'h0 || block !== 512'h0) begin
      n_fail++; $display("FAIL abort_outputs arvalid=%b rready=%b we=%b fault=%b araddr=%h exp=all zero", arvalid, rready, we, fault, araddr); end
    @(negedge clk);
    rvalid = 1'b0; rlast = 1'b0; hit = 1'b1;
    @(negedge clk);
    arst = 1'b0;
    set_trial(64'h100, 0, 7);
    for (int i = 0; i < 8; i++) tr_data[i] = {$urandom, $urandom};
    run_miss();
    n_checks++; if (ob_hs_addr !== 64'h100 || ob_t_we != 11) begin n_fail++; $display("FAIL post_abort araddr=%h we_cycle=%0d exp=100/11", ob_hs_addr, ob_t_we); end
    n_checks++; if (ob_blk !== model_block()) begin n_fail++; $display("FAIL post_abort_block got=%h exp=%h", ob_blk, model_block()); end
  endtask

  task automatic test_random();
    int r;
    bit exp_fault;
    for (int t = 0; t < 24; t++) begin
      r = $urandom_range(0, 5);
      set_trial({$urandom, $urandom}, $urandom_range(0, 3), (r == 0) ? $urandom_range(2, 6) : ((r == 1) ? 8 : 7));
      for (int i = 0; i < 8; i++) begin
        tr_data[i] = {$urandom, $urandom};
        tr_resp[i] = ($urandom_range(0, 11) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        if (i > 0) tr_gap[i] = $urandom_range(0, 2);
      end
      exp_fault = model_fault();
      run_miss();
      n_checks++; if (ob_timeout) begin n_fail++; $display("FAIL rnd%0d_timeout got=no completion exp=completion", t); end
      n_checks++; if (ob_fault != exp_fault) begin n_fail++; $display("FAIL rnd%0d_fault got=%0d exp=%0d", t, ob_fault, exp_fault); end
      if (exp_fault) begin
        n_checks++; if (ob_n_we != 0) begin n_fail++; $display("FAIL rnd%0d_we_on_fault got=%0d exp=0", t, ob_n_we); end
        apply_reset();
      end else begin
        n_checks++; if (ob_t_we != 11 + model_extra() || ob_n_we != 1) begin
          n_fail++; $display("FAIL rnd%0d_we cycle=%0d count=%0d exp=%0d/1", t, ob_t_we, ob_n_we, 11 + model_extra()); end
        n_checks++; if (ob_blk !== model_block()) begin n_fail++; $display("FAIL rnd%0d_block got=%h exp=%h", t, ob_blk, model_block()); end
        n_checks++; if (ob_hs_addr !== {tr_pc[63:6], 6'b0} || ob_addr_bad != 0) begin
          n_fail++; $display("FAIL rnd%0d_araddr got=%h exp=%h", t, ob_hs_addr, {tr_pc[63:6], 6'b0}); end
        n_checks++; if (ob_n_stall != 12 + model_extra()) begin
          n_fail++; $display("FAIL rnd%0d_stall got=%0d exp=%0d", t, ob_n_stall, 12 + model_extra()); end
      end
    end
  endtask

  initial begin
    arst = 1'b1; hit = 1'b1; read_addr = '0; arready = 1'b0;
    rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    tr_abort_beat = -1;
    repeat (2) @(negedge clk);
    arst = 1'b0;
    test_reset();
    test_hit_only();
    test_basic_miss();
    test_ar_wait_gaps();
    test_resp_error();
    test_early_last();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
